// File: rtl/fc_sched.sv
// fc_sched: round-robin scheduler sharing one FC engine among NUM_REQ cores.
// Optional WAIT watchdog enabled by FC_SCHED_TIMEOUT_EN.
module fc_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*9*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        eng_rst,
  output logic                        eng_enable,
  output logic [9*DATA_W-1:0]         eng_input,
  input  logic                        eng_done,
  input  logic [DATA_W-1:0]           eng_result,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int VW = 9 * DATA_W;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, sel_q, pick;
  logic [VW-1:0]     eng_input_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              eng_rst_q, found, expire;
  int                rr_idx;
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (int'(ptr_q) + 1 + k) % NUM_REQ;
      if (!found && req[rr_idx]) begin
        pick  = IW'(rr_idx);
        found = 1'b1;
      end
    end
  end
`ifdef FC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          to_q;
  assign expire = (cnt_q == CW'(TIMEOUT - 1)) && !eng_done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      to_q  <= (state_q == WAIT) && expire;
    end
  end
  assign timeout_err = to_q && (state_q == RESP);
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = found ? CLEAR : IDLE;
      CLEAR:   state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (eng_done || expire) ? RESP : WAIT;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= IW'(NUM_REQ - 1);
      sel_q       <= '0;
      eng_input_q <= '0;
      rsp_data_q  <= '0;
      eng_rst_q   <= 1'b1;
    end else begin
      eng_rst_q <= (state_d == CLEAR);
      if (state_q == IDLE && found) begin
        sel_q       <= pick;
        eng_input_q <= req_data[int'(pick)*VW +: VW];
      end
      if (state_q == WAIT && (eng_done || expire)) rsp_data_q <= eng_done ? eng_result : '0;
      if (state_q == RESP) ptr_q <= sel_q;
    end
  end
  always_comb begin
    gnt        = (state_q == CLEAR) ? ONE << sel_q : '0;
    rsp_valid  = (state_q == RESP) ? ONE << sel_q : '0;
    eng_enable = (state_q == ISSUE);
    busy       = (state_q != IDLE);
    eng_rst    = eng_rst_q;
    eng_input  = eng_input_q;
    rsp_data   = rsp_data_q;
  end
endmodule

// File: tb/tb_fc_sched.sv
// tb_fc_sched: directed checks of fc_sched against a one-cycle-latency engine model.
module tb_fc_sched;
  localparam int N = 4, W = 32, VW = 9 * W;
  logic           clk = 1'b0, rst_n = 1'b0, eng_done = 1'b0, stuck = 1'b0;
  logic [N-1:0]   req = '0, gnt, rsp_valid, g, rv;
  logic [N*VW-1:0] req_data;
  logic           eng_rst, eng_enable, busy, timeout_err;
  logic [VW-1:0]  eng_input;
  logic [W-1:0]   eng_result, rsp_data, rd;
  int             checks = 0, errors = 0, en_cnt = 0, en0, cyc;
  int             ord[5] = '{0, 1, 2, 3, 0};

  fc_sched #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .eng_rst(eng_rst), .eng_enable(eng_enable), .eng_input(eng_input),
    .eng_done(eng_done), .eng_result(eng_result), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (eng_rst) eng_done <= 1'b0;
    else if (eng_enable && !stuck) eng_done <= 1'b1;
    if (eng_enable) en_cnt <= en_cnt + 1;
  end
  assign eng_result = eng_input[W-1:0];

  function automatic logic [VW-1:0] mk(input int c);
    for (int e = 0; e < 9; e++) mk[e*W +: W] = W'(100 + c + 10 * e);
  endfunction
  always_comb for (int c = 0; c < N; c++) req_data[c*VW +: VW] = mk(c);

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    step();
    check("rst_busy", busy, 0);
    check("rst_eng_rst", eng_rst, 1);
    check("rst_outs", {gnt, rsp_valid, eng_enable, timeout_err}, 0);
    check("rst_data", {eng_input, rsp_data}, 0);
    rst_n = 1'b1;
  endtask
  task automatic wait_gnt(output logic [N-1:0] gg, output int cc, output logic [N-1:0] rvo, output logic [W-1:0] rdo);
    rvo = '0;
    rdo = '0;
    cc = 1;
    step();
    while (gnt == 0 && cc < 20) begin
      if (rsp_valid != 0) begin rvo = rsp_valid; rdo = rsp_data; end
      step();
      cc++;
    end
    gg = gnt;
    check("gnt_seen", gnt != 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    step(2);
    do_reset();
    req = 4'b0001;
    en0 = en_cnt;
    step();
    check("s_gnt", gnt, 4'b0001);
    check("s_clear", {eng_rst, busy, eng_enable}, 3'b110);
    check("s_input", eng_input, mk(0));
    req = '0;
    step();
    check("s_issue", {eng_enable, eng_rst, gnt}, 6'b100000);
    step();
    check("s_wait", {eng_enable, rsp_valid}, 0);
    step();
    check("s_rsp", rsp_valid, 4'b0001);
    check("s_rdata", rsp_data, 100);
    check("s_hold_input", eng_input, mk(0));
    step();
    check("s_idle", {busy, rsp_valid}, 0);
    check("s_rdata_hold", rsp_data, 100);
    check("s_en_cycles", en_cnt - en0, 1);

    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, cyc, rv, rd);
      check("rr_order", g, 4'b0001 << ord[i]);
      if (i > 0) begin
        check("rr_gap", cyc, 5);
        check("rr_rsp", rv, 4'b0001 << ord[i-1]);
        check("rr_rdata", rd, 100 + ord[i-1]);
      end
    end
    req = '0;
    step(3);
    check("rr_last_rsp", rsp_valid, 4'b0001);
    step();

    do_reset();
    req = 4'b0010;
    wait_gnt(g, cyc, rv, rd);
    check("drop_pre_gnt", g, 4'b0010);
    req = '0;
    step(4);
    req = 4'b1101;
    wait_gnt(g, cyc, rv, rd);
    check("drop_gnt2", g, 4'b0100);
    step();
    req = 4'b1001;
    wait_gnt(g, cyc, rv, rd);
    check("drop_rsp2", rv, 4'b0100);
    check("drop_rdata2", rd, 102);
    check("drop_next3", g, 4'b1000);
    req = '0;
    step(4);

    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    step(2);
    check("mid_wait_busy", {busy, eng_enable}, 2'b10);
    rst_n = 1'b0;
    step();
    check("mid_rst_state", {busy, eng_rst, rsp_valid}, 6'b010000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mid_no_rsp", rsp_valid, 0);
      step();
    end
    req = 4'b0010;
    wait_gnt(g, cyc, rv, rd);
    check("mid_new_gnt", g, 4'b0010);
    req = '0;
    step(3);
    check("mid_new_rsp", rsp_valid, 4'b0010);
    check("mid_new_rdata", rsp_data, 101);
    step();

    stuck = 1'b1;
    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    cyc = 0;
`ifdef FC_SCHED_TIMEOUT_EN
    while (rsp_valid == 0 && cyc < 200) begin step(); cyc++; end
    check("to_latency", cyc, 66);
    check("to_pulse", {timeout_err, rsp_valid}, 5'b10001);
    check("to_rdata", rsp_data, 0);
    step();
    check("to_after", {timeout_err, busy}, 0);
`else
    rv = '0;
    repeat (100) begin
      step();
      rv = rv | rsp_valid;
      cyc = cyc + int'(timeout_err);
    end
    check("stuck_busy", busy, 1);
    check("stuck_no_rsp", rv, 0);
    check("stuck_no_to", cyc, 0);
`endif
    stuck = 1'b0;
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_sched.md
FC_SCHED -- requirements
Module: fc_sched

Interface
REQ-001 SHALL expose parameter NUM_REQ, default 4, number of requesting cores sharing one FC engine (2..8).
REQ-002 SHALL expose parameter DATA_W, default 32, signed element and result width.
REQ-003 SHALL expose parameter TIMEOUT, default 64, watchdog limit in cycles for engine completion.
REQ-004 SHALL have port clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-core request; held high until served.
REQ-007 SHALL have port req_data  input  NUM_REQ*9*DATA_W  per-core 9-element input vector; core i occupies slice i.
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse.
REQ-009 SHALL have port eng_rst  output  1  active-high clear to the FC engine.
REQ-010 SHALL have port eng_enable  output  1  engine compute strobe.
REQ-011 SHALL have port eng_input  output  9*DATA_W  latched vector driven to the engine.
REQ-012 SHALL have port eng_done  input  1  engine completion flag (sticky until eng_rst).
REQ-013 SHALL have port eng_result  input  DATA_W  engine result.
REQ-014 SHALL have port rsp_valid  output  NUM_REQ  one-hot response strobe to the served core.
REQ-015 SHALL have port rsp_data  output  DATA_W  result for the core flagged by rsp_valid.
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-017 SHALL have port timeout_err  output  1  one-cycle abort pulse.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, CLEAR, ISSUE, WAIT and RESP; all outputs SHALL be decoded from registered state.
REQ-019 IDLE: if any req bit is high, SHALL select a core round-robin, starting at the index after the last served core, latch its req_data slice into eng_input and go to CLEAR; otherwise SHALL remain in IDLE.
REQ-020 CLEAR: SHALL assert gnt[sel] and eng_rst for exactly one cycle, then go to ISSUE.
REQ-021 ISSUE: SHALL assert eng_enable for exactly one cycle, never more, because the engine accumulates on every enabled cycle; SHALL then go to WAIT.
REQ-022 WAIT: when eng_done is high, SHALL capture eng_result into rsp_data and go to RESP.
REQ-023 RESP: SHALL assert rsp_valid[sel] for one cycle, advance the round-robin pointer to sel, then return to IDLE.
REQ-024 With an engine whose done follows enable by one cycle, rsp_valid SHALL assert 4 cycles after the IDLE edge that accepted the request; back-to-back service SHALL take 5 cycles per transaction.
REQ-025 Deassertion of req before selection SHALL withdraw the request; deassertion after gnt SHALL be ignored, and the transaction SHALL complete with rsp_valid still pulsed.
REQ-026 eng_input SHALL stay stable from CLEAR through RESP; req_data needs to be valid only in the selecting cycle.
REQ-027 rsp_data SHALL hold its value until the next capture; gnt, rsp_valid and timeout_err SHALL be zero outside their defined cycles.
REQ-028 The round-robin rotation SHALL guarantee that any continuously asserted request is served within NUM_REQ transactions.

Reset
REQ-029 On rst_n low at a clock edge, the block SHALL enter IDLE, set the round-robin pointer to NUM_REQ-1 (so core 0 is first), clear eng_input and rsp_data to 0, and drive gnt, rsp_valid, eng_enable, busy and timeout_err to 0 and eng_rst to 1.
REQ-030 Reset mid-transaction SHALL abort it with no rsp_valid for the aborted core.

Configuration
REQ-031 Macro FC_SCHED_TIMEOUT_EN, when defined, SHALL add a WAIT-state cycle counter; at count TIMEOUT without eng_done, the block SHALL pulse timeout_err, pulse rsp_valid[sel] with rsp_data=0, and return to IDLE through RESP.
REQ-032 Without FC_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, and timeout_err SHALL be tied to 0.

Verification
REQ-033 Single request, req=4'b0001, engine returns 100 -> gnt=0001 at cycle +1, eng_enable high exactly 1 cycle, rsp_valid=0001 and rsp_data=100 at cycle +4.
REQ-034 All four requests held after reset -> grants issue in order 0,1,2,3,0, each 5 cycles apart.
REQ-035 req[2] dropped in the cycle after gnt[2] -> rsp_valid[2] still pulses, and the next grant goes to core 3.
REQ-036 rst_n low during WAIT -> next cycle busy=0, eng_rst=1 and no rsp_valid; a new request then completes normally.
REQ-037 With FC_SCHED_TIMEOUT_EN and eng_done stuck at 0 -> timeout_err and rsp_valid pulse with rsp_data=0 after 64 WAIT cycles; without the macro, busy stays 1.
